wishbone_fft_master: RTL
========================

# wishbone_fft_master

Wishbone bus master that drives the FFT accelerator's Wishbone slave through one complete job: it loads `sample` complex samples, writes the start bit, polls the done flag, and reads back all results. It bridges a simple valid/ready sample stream on the user side to classic single-transaction Wishbone cycles on the bus side. It sits between the host datapath and the accelerator's register window.

## Interface
Parameters:
- `sample`, 8: samples per job; must equal the slave's setting.
- `n_bit_for_sample`, 3: index width, log2(`sample`); the address is `5 + n_bit_for_sample` bits.
- `POLL_LIMIT`, 1024: maximum status reads before a timeout error.
- `ACK_TIMEOUT`, 16: maximum cycles to wait for `ACK_I` within one bus cycle.

Ports:
- Reset is synchronous and active-low on `RST_I`, with one clock `CLK_I`. There is no other clock or reset.
- `CLK_I`  in  1  clock.
- `RST_I`  in  1  synchronous, active-low reset.
- `go`  in  1  single-cycle pulse that starts a job; ignored while `busy`.
- `in_valid`  in  1 / `in_ready`  out  1: sample input handshake.
- `in_re`, `in_im`  in  32 each: signed sample, real and imaginary parts.
- `out_valid`  out  1 / `out_ready`  in  1: result output handshake.
- `out_re`, `out_im`  out  32 each: signed result, real and imaginary parts.
- `out_idx`  out  `n_bit_for_sample`: index of the current result.
- `busy`  out  1: high from the cycle after an accepted `go` until the job ends.
- `finished`  out  1: one-cycle pulse on successful completion.
- `error`  out  1: sticky; set on timeout, cleared by the next accepted `go`.
- `CYC_O`, `STB_O`, `WE_O`  out  1 each: Wishbone cycle, strobe and write-enable.
- `ADR_O`  out  `5+n_bit_for_sample`: Wishbone address.
- `DAT_O`  out  32: write data.
- `DAT_I`  in  32: read data.
- `ACK_I`  in  1: slave acknowledge.

## Operation
Address layout:
- `ADR_O` = {region[4:0], idx}.
- Regions: CTRL 5'h00, STATUS 5'h01, WR_RE 5'h02, WR_IM 5'h04, RD_RE 5'h06, RD_IM 5'h08.

State machine states: IDLE, LOAD_WAIT, WR_RE, WR_IM, START, POLL, RD_RE, RD_IM, EMIT, DONE, ERR.
- **IDLE:** on `go`, clear `error`, set idx to 0, go to LOAD_WAIT.
- **LOAD_WAIT:** assert `in_ready`. On `in_valid`, capture both parts and go to WR_RE.
- **WR_RE:** write `in_re` to {WR_RE, idx}.
- **WR_IM:** write `in_im` to {WR_IM, idx}.
  - If idx = `sample`-1, go to START.
  - Otherwise increment idx and return to LOAD_WAIT.
  - The imaginary write must always follow the real write for the same idx, because the slave counts samples on imaginary writes only.
- **START:** write 32'h1 to {CTRL, 0}, then go to POLL.
- **POLL:** read {STATUS, 0}.
  - If `DAT_I[0]` is 1, set idx to 0 and go to RD_RE.
  - Otherwise increment the poll counter and repeat.
  - When the counter reaches `POLL_LIMIT`, go to ERR.
- **RD_RE:** read {RD_RE, idx} and latch the result into `out_re`.
- **RD_IM:** read {RD_IM, idx}, latch the result into `out_im`, go to EMIT.
- **EMIT:** assert `out_valid` and hold `out_*` stable until `out_ready`.
  - Then increment idx, or go to DONE after the last index.
- **DONE:** pulse `finished`, return to IDLE.
- **ERR:** set `error`, return to IDLE with the bus released.

Bus cycle rules (apply to every transaction):
- Registered request drives `CYC_O`, `WE_O`, `ADR_O` and `DAT_O`.
- `STB_O` = stb_q & ~`ACK_I`, and `CYC_O` = cyc_q & ~`ACK_I`. These are combinational so the slave never sees a second strobe on the ACK cycle.
- Read data is captured from `DAT_I` on the edge where `ACK_I`=1. `DAT_I` is ignored at all other times.
- After each ACK, there is at least one idle cycle with `CYC_O`=`STB_O`=0 before the next request.
- If `ACK_TIMEOUT` cycles pass without `ACK_I`, drop the request and go to ERR.

## Timing
- Reset (`RST_I`=0 at an edge) forces:
  - state to IDLE;
  - all bus outputs and `DAT_O`/`ADR_O` to 0;
  - `in_ready`, `out_valid`, `busy`, `finished` and `error` to 0;
  - `out_*` to 0.
- A reset in the middle of a job aborts immediately, with no bus cleanup cycle.
- `go` is accepted in IDLE only and produces the first request in LOAD_WAIT→WR_RE.
- The master issues its request one cycle after it enters a bus state. The request is held until `ACK_I`.
- Against the current slave:
  - a write takes 4 cycles from request to ACK, plus 1 idle cycle;
  - a read takes 6 cycles, plus 1 idle cycle.
- `ACK_I` arriving while no request is outstanding is ignored.
- All index counters and poll counters saturate, never wrap.

## Structure
- Shared package `wb_fft_pkg` holds:
  - the region constants;
  - the state enum;
  - the address-build function {region, idx}.
- A natural sub-module is `wb_master_port`, the single-transaction engine. It handles request/ACK/timeout and the `STB_O` gating, and takes req, we, adr and wdat in, returning rdat, done and timeout.
- The sequencer FSM stays in the top level.

## Test plan
- With the slave model, `sample`=8: stream samples (i, -i) for i = 0..7 → 16 writes in the order re/im per index, then CTRL=1. An identity slave returns them → `out_re`=i and `out_im`=-i in idx order, then `finished` pulses once.
- Done held low for 3 polls, then high → exactly 4 STATUS reads at address 8'h08, then the first RD_RE read at 8'h30.
- Slave never acks, `ACK_TIMEOUT`=16 → request drops after 16 cycles, `error`=1, `busy`=0. The next `go` clears `error`.
- `out_ready` held low for 5 cycles on idx 3 → `out_*` stable, with no bus activity during the stall.
- `RST_I`=0 asserted during WR_IM of idx 2 → all outputs 0 on the next edge. A fresh `go` restarts from idx 0.
- Bus check on every ACK cycle: `STB_O`=0 on the ACK cycle, and one idle cycle before the next request. No duplicate WR_IM write is observed at the slave.

Source files
------------

// File: rtl/wishbone_fft_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_fft_pkg
// Brief    : Shared region map, sequencer states and address helper for the
//            FFT Wishbone master.
// Revision : 1.0
// ============================================================================
package wb_fft_pkg;

  localparam logic [4:0] c_rgn_ctrl   = 5'h00;
  localparam logic [4:0] c_rgn_status = 5'h01;
  localparam logic [4:0] c_rgn_wr_re  = 5'h02;
  localparam logic [4:0] c_rgn_wr_im  = 5'h04;
  localparam logic [4:0] c_rgn_rd_re  = 5'h06;
  localparam logic [4:0] c_rgn_rd_im  = 5'h08;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_WAIT,
    ST_WR_RE,
    ST_WR_IM,
    ST_START,
    ST_POLL,
    ST_RD_RE,
    ST_RD_IM,
    ST_EMIT,
    ST_DONE,
    ST_ERR
  } state_t;

  // Caller truncates the result to its own 5+idx_bits address width.
  function automatic logic [20:0] build_adr(input logic [4:0]  region,
                                            input logic [15:0] idx,
                                            input int          idx_bits);
    build_adr = (21'(region) << idx_bits) | 21'(idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wishbone_fft_master_if.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_fft_master_if
// Brief    : Classic Wishbone single-transaction bus bundle.
// Revision : 1.0
// ============================================================================
interface wishbone_fft_master_if #(
  parameter int AW = 8
);
  logic          CYC_O;
  logic          STB_O;
  logic          WE_O;
  logic [AW-1:0] ADR_O;
  logic [31:0]   DAT_O;
  logic [31:0]   DAT_I;
  logic          ACK_I;

  modport master (output CYC_O, STB_O, WE_O, ADR_O, DAT_O, input DAT_I, ACK_I);
  modport slave  (input CYC_O, STB_O, WE_O, ADR_O, DAT_O, output DAT_I, ACK_I);
endinterface
`default_nettype wire

// File: rtl/wishbone_fft_master_port.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_port
// Brief    : Single-transaction Wishbone engine with ACK timeout.
// Revision : 1.0
// ============================================================================
module wb_master_port #(
  parameter int AW          = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  wire logic          CLK_I,
  input  wire logic          RST_I,
  input  wire logic          req,
  input  wire logic          we,
  input  wire logic [AW-1:0] adr,
  input  wire logic [31:0]   wdat,
  output logic      [31:0]   rdat,
  output logic               done,
  output logic               timeout,
  wishbone_fft_master_if.master wb
);
  localparam int             c_tw        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_wait_last = c_tw'(ACK_TIMEOUT - 1);
  localparam logic [c_tw-1:0] c_wait_one  = c_tw'(1);

  logic            r_cyc;
  logic            r_stb;
  logic            r_we;
  logic [AW-1:0]   r_adr;
  logic [31:0]     r_dat;
  logic [c_tw-1:0] r_wait;

  // Gating by ACK_I keeps the slave from seeing a second strobe on the ACK cycle.
  assign wb.CYC_O = r_cyc & ~wb.ACK_I;
  assign wb.STB_O = r_stb & ~wb.ACK_I;
  assign wb.WE_O  = r_we;
  assign wb.ADR_O = r_adr;
  assign wb.DAT_O = r_dat;

  assign rdat    = wb.DAT_I;
  assign done    = r_stb & wb.ACK_I;
  assign timeout = r_stb & ~wb.ACK_I & (r_wait == c_wait_last);

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_cyc  <= 1'b0;
      r_stb  <= 1'b0;
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_wait <= '0;
    end else if (r_stb) begin
      if (done || timeout) begin
        r_cyc  <= 1'b0;
        r_stb  <= 1'b0;
        r_we   <= 1'b0;
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + c_wait_one;
      end
    end else if (req) begin
      r_cyc  <= 1'b1;
      r_stb  <= 1'b1;
      r_we   <= we;
      r_adr  <= adr;
      r_dat  <= wdat;
      r_wait <= '0;
    end
  end
endmodule
`default_nettype wire

// File: rtl/wishbone_fft_master.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_fft_master
// Brief    : Sequences one FFT job over Wishbone: load, start, poll, read back.
// Revision : 1.0
// ============================================================================
module wishbone_fft_master
  import wb_fft_pkg::*;
#(
  parameter int sample           = 8,
  parameter int n_bit_for_sample = 3,
  parameter int POLL_LIMIT       = 1024,
  parameter int ACK_TIMEOUT      = 16
) (
  input  wire logic                        CLK_I,
  input  wire logic                        RST_I,
  input  wire logic                        go,
  input  wire logic                        in_valid,
  output logic                             in_ready,
  input  wire logic [31:0]                 in_re,
  input  wire logic [31:0]                 in_im,
  output logic                             out_valid,
  input  wire logic                        out_ready,
  output logic      [31:0]                 out_re,
  output logic      [31:0]                 out_im,
  output logic      [n_bit_for_sample-1:0] out_idx,
  output logic                             busy,
  output logic                             finished,
  output logic                             error,
  wishbone_fft_master_if.master            wb
);
  localparam int                           c_aw       = 5 + n_bit_for_sample;
  localparam int                           c_pw       = $clog2(POLL_LIMIT + 1);
  localparam logic [n_bit_for_sample-1:0]  c_idx_last = n_bit_for_sample'(sample - 1);
  localparam logic [n_bit_for_sample-1:0]  c_idx_one  = n_bit_for_sample'(1);
  localparam logic [c_pw-1:0]              c_poll_last = c_pw'(POLL_LIMIT - 1);
  localparam logic [c_pw-1:0]              c_poll_one  = c_pw'(1);

  state_t                      r_state;
  logic [n_bit_for_sample-1:0] r_idx;
  logic [c_pw-1:0]             r_poll;
  logic [31:0]                 r_re;
  logic [31:0]                 r_im;

  logic                        w_req;
  logic                        w_we;
  logic [4:0]                  w_region;
  logic [n_bit_for_sample-1:0] w_idx;
  logic [31:0]                 w_wdat;
  logic [c_aw-1:0]             w_adr;
  logic [31:0]                 w_rdat;
  logic                        w_done;
  logic                        w_timeout;

  always_comb begin
    w_req    = 1'b0;
    w_we     = 1'b0;
    w_region = c_rgn_ctrl;
    w_idx    = r_idx;
    w_wdat   = '0;
    case (r_state)
      ST_WR_RE: begin w_req = 1'b1; w_we = 1'b1; w_region = c_rgn_wr_re; w_wdat = r_re; end
      ST_WR_IM: begin w_req = 1'b1; w_we = 1'b1; w_region = c_rgn_wr_im; w_wdat = r_im; end
      ST_START: begin w_req = 1'b1; w_we = 1'b1; w_idx = '0; w_wdat = 32'h1; end
      ST_POLL:  begin w_req = 1'b1; w_region = c_rgn_status; w_idx = '0; end
      ST_RD_RE: begin w_req = 1'b1; w_region = c_rgn_rd_re; end
      ST_RD_IM: begin w_req = 1'b1; w_region = c_rgn_rd_im; end
      default:  ;
    endcase
    w_adr = c_aw'(build_adr(w_region, 16'(w_idx), n_bit_for_sample));
  end

  wb_master_port #(
    .AW          (c_aw),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_port (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .req     (w_req),
    .we      (w_we),
    .adr     (w_adr),
    .wdat    (w_wdat),
    .rdat    (w_rdat),
    .done    (w_done),
    .timeout (w_timeout),
    .wb      (wb)
  );

  assign out_idx = r_idx;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_poll    <= '0;
      r_re      <= '0;
      r_im      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      error     <= 1'b0;
    end else begin
      finished <= 1'b0;
      if (w_timeout) begin
        r_state <= ST_ERR;
      end else begin
        case (r_state)
          ST_IDLE: if (go) begin
            error    <= 1'b0;
            r_idx    <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            r_state  <= ST_LOAD_WAIT;
          end
          ST_LOAD_WAIT: if (in_valid) begin
            r_re     <= in_re;
            r_im     <= in_im;
            in_ready <= 1'b0;
            r_state  <= ST_WR_RE;
          end
          ST_WR_RE: if (w_done) r_state <= ST_WR_IM;
          // The slave counts samples on imaginary writes, so idx only moves here.
          ST_WR_IM: if (w_done) begin
            if (r_idx == c_idx_last) begin
              r_state <= ST_START;
            end else begin
              r_idx    <= r_idx + c_idx_one;
              in_ready <= 1'b1;
              r_state  <= ST_LOAD_WAIT;
            end
          end
          ST_START: if (w_done) begin
            r_poll  <= '0;
            r_state <= ST_POLL;
          end
          ST_POLL: if (w_done) begin
            if (w_rdat[0]) begin
              r_idx   <= '0;
              r_state <= ST_RD_RE;
            end else if (r_poll == c_poll_last) begin
              r_state <= ST_ERR;
            end else begin
              r_poll <= r_poll + c_poll_one;
            end
          end
          ST_RD_RE: if (w_done) begin
            out_re  <= w_rdat;
            r_state <= ST_RD_IM;
          end
          ST_RD_IM: if (w_done) begin
            out_im    <= w_rdat;
            out_valid <= 1'b1;
            r_state   <= ST_EMIT;
          end
          ST_EMIT: if (out_ready) begin
            out_valid <= 1'b0;
            if (r_idx == c_idx_last) begin
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + c_idx_one;
              r_state <= ST_RD_RE;
            end
          end
          ST_DONE: begin
            finished <= 1'b1;
            busy     <= 1'b0;
            r_state  <= ST_IDLE;
          end
          ST_ERR: begin
            error    <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            r_state  <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
`default_nettype wire
